// File: rtl/gpc_div_pkg.sv
// Shared constants for the sequential divider: default width, FSM state
// encoding and the quotient value reported on divide-by-zero.
package gpc_div_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  localparam logic [DIV_WIDTH_DEF-1:0] DIV_ZERO_QUOT = '1;

  typedef logic [1:0] div_state_t;

  localparam div_state_t ST_IDLE = 2'd0;
  localparam div_state_t ST_CALC = 2'd1;
  localparam div_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/divider32_seq_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
  import gpc_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quot_bit_o
);

  logic [WIDTH:0] rem_t;
  logic [WIDTH:0] diff;

  // The extra top bit keeps the shifted remainder intact when the divisor
  // uses the full width; a clear borrow bit means the divisor fits.
  assign rem_t      = {rem_i, dvd_msb_i};
  assign diff       = rem_t - {1'b0, divisor_i};
  assign quot_bit_o = ~diff[WIDTH];
  assign rem_o      = quot_bit_o ? diff[WIDTH-1:0] : rem_t[WIDTH-1:0];

endmodule

// File: rtl/divider32_seq.sv
// Iterative radix-2 restoring divider with valid/ready handshakes on both sides.
// Signed operation is compiled in only when DIV32_SIGNED_EN is defined.
module divider32_seq
  import gpc_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] part_rem_q, part_rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div_zero_q, div_zero_d;

  logic             signed_op;
  logic             neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] quot_raw;

`ifdef DIV32_SIGNED_EN
  assign signed_op = in_signed;
`else
  assign signed_op = in_signed & 1'b0;
`endif

  // The core only ever sees magnitudes; signs are restored on completion.
  assign neg1 = signed_op & in1[WIDTH-1];
  assign neg2 = signed_op & in2[WIDTH-1];
  assign mag1 = neg1 ? -in1 : in1;
  assign mag2 = neg2 ? -in2 : in2;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i      (part_rem_q),
    .dvd_msb_i  (dvd_q[WIDTH-1]),
    .divisor_i  (dsr_q),
    .rem_o      (step_rem),
    .quot_bit_o (step_bit)
  );

  // Quotient bits fill the dividend register as its bits are consumed.
  assign quot_raw = {dvd_q[WIDTH-2:0], step_bit};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    part_rem_d = part_rem_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in2 == '0) begin
            state_d    = ST_DONE;
            quot_d     = DIV_ZERO_QUOT[WIDTH-1:0];
            rem_d      = in1;
            div_zero_d = 1'b1;
          end else begin
            state_d    = ST_CALC;
            cnt_d      = '0;
            part_rem_d = '0;
            dvd_d      = mag1;
            dsr_d      = mag2;
            neg_quot_d = neg1 ^ neg2;
            neg_rem_d  = neg1;
            div_zero_d = 1'b0;
          end
        end
      end
      ST_CALC: begin
        part_rem_d = step_rem;
        dvd_d      = quot_raw;
        cnt_d      = cnt_q + CNT_W'(1);
        // The final iteration publishes the sign-corrected result directly.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          quot_d  = neg_quot_q ? -quot_raw : quot_raw;
          rem_d   = neg_rem_q ? -step_rem : step_rem;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      part_rem_q <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      part_rem_q <= part_rem_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_divider32_seq.sv
// Self-checking bench for divider32_seq: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_divider32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  divider32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; signed mode truncates toward zero.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
    dz = 1'b0;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
`ifdef DIV32_SIGNED_EN
      if (s) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000;
          r = 32'd0;
        end else begin
          q = 32'($signed(a) / $signed(b));
          r = 32'($signed(a) % $signed(b));
        end
      end
`else
      if (s) q = a / b;
`endif
    end
  endtask

  // Runs one division; called and returning at 1 time unit after a rising edge.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int hold, input bit poke);
    logic [31:0] eq, er;
    logic        edz;
    int          lat;
    ref_div(a, b, s, eq, er, edz);
    in1 = a; in2 = b; in_signed = s; in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom; in_signed = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_lat"}, 64'(lat), edz ? 64'd1 : 64'd33);
    check({tag, "_res"}, {quot, rem}, {eq, er});
    check({tag, "_dz"}, 64'(div_zero), 64'(edz));
    repeat (hold) begin
      if (poke) begin
        in_valid = 1'b1; in1 = $urandom; in2 = $urandom_range(1, 50);
      end
      @(posedge clk); #1;
      check({tag, "_hold"}, {quot, rem}, {eq, er});
      check({tag, "_hold_hs"}, {62'd0, out_valid, in_ready}, 64'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_consume"}, {62'd0, out_valid, in_ready}, 64'b01);
    in_valid = 1'b0;
  endtask

  initial begin
    logic        seen;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; in_signed = 1'b0; out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_hs", {62'd0, out_valid, in_ready}, 64'b01);
    check("reset_res", {quot, rem}, 64'd0);
    check("reset_dz", 64'(div_zero), 64'd0);
    rst = 1'b0;

    run_div("u100_7", 32'd100, 32'd7, 1'b0, 0, 1'b0);
    run_div("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0);
    run_div("umax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    run_div("ubig_div", 32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 0, 1'b0);
    run_div("dz", 32'd12345, 32'd0, 1'b0, 0, 1'b0);
    run_div("bp", 32'd1000, 32'd33, 1'b0, 10, 1'b1);

    // Abort part-way through a division with a synchronous reset.
    in1 = 32'd1000; in2 = 32'd7; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_hs", {62'd0, out_valid, in_ready}, 64'b01);
    check("midrst_res", {quot, rem}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("midrst_novalid", 64'(seen), 64'd0);
    run_div("u9_3", 32'd9, 32'd3, 1'b0, 0, 1'b0);

`ifdef DIV32_SIGNED_EN
    run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_div("s_dz", 32'hFFFF_FFF9, 32'd0, 1'b1, 0, 1'b0);
    run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(1, 255));
        1:       rb = (i % 8 == 0) ? 32'd0 : $urandom;
        2:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_div($sformatf("rnd%0d", i), ra, rb, 1'($urandom), i % 5, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
